// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the MIPS datapath: ALU control decode, operand
// forwarding from EX/MEM and MEM/WB, load-use stall detection and bubble insertion.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              idValid,
  input  logic [1:0]        idAluOp,
  input  logic [5:0]        idFunct,
  input  logic              idAluSrc,
  input  logic              idRegDst,
  input  logic              idRegWrite,
  input  logic              idMemRead,
  input  logic              idMemWrite,
  input  logic              idMemToReg,
  input  logic              idBranch,
  input  logic [REG_AW-1:0] idRs,
  input  logic [REG_AW-1:0] idRt,
  input  logic [REG_AW-1:0] idRd,
  input  logic [DATA_W-1:0] idReadData1,
  input  logic [DATA_W-1:0] idReadData2,
  input  logic [DATA_W-1:0] idImm,
  input  logic              exmemRegWrite,
  input  logic [REG_AW-1:0] exmemRd,
  input  logic [DATA_W-1:0] exmemAluRes,
  input  logic              memwbRegWrite,
  input  logic [REG_AW-1:0] memwbRd,
  input  logic [DATA_W-1:0] memwbData,
  input  logic              flush,
  output logic              stall,
  output logic [DATA_W-1:0] aluInput1,
  output logic [DATA_W-1:0] aluInput2,
  output logic [3:0]        aluCtr,
  output logic [DATA_W-1:0] storeData,
  output logic [REG_AW-1:0] exDest,
  output logic              exRegWrite,
  output logic              exMemRead,
  output logic              exMemWrite,
  output logic              exMemToReg,
  output logic              exBranch,
  output logic              exValid,
  output logic              illegal
);

  logic [3:0]        ctr_d;
  logic              illegal_d;
  logic              bubble;
  logic [REG_AW-1:0] rs_q, rt_q;
  logic [DATA_W-1:0] rd1_q, rd2_q, imm_q;
  logic              alu_src_q;
  logic [DATA_W-1:0] fwd_a, fwd_b;

  always_comb begin
    ctr_d     = 4'b0010;
    illegal_d = 1'b0;
    case (idAluOp)
      2'b01: ctr_d = 4'b0110;
      2'b10: begin
        case (idFunct)
          6'b100000: ctr_d = 4'b0010;
          6'b100010: ctr_d = 4'b0110;
          6'b100100: ctr_d = 4'b0000;
          6'b100101: ctr_d = 4'b0001;
          6'b101010: ctr_d = 4'b0111;
          6'b100111: ctr_d = 4'b1100;
          default:   illegal_d = 1'b1;
        endcase
      end
      default: ctr_d = 4'b0010;
    endcase
  end

  // Load-use: the load in EX cannot supply its data until after MEM.
  assign stall = exValid && exMemRead && (exDest != '0) &&
                 ((exDest == idRs) || (exDest == idRt)) && idValid;

  assign bubble = stall || flush || !idValid;

  always_ff @(posedge clk) begin
    if (reset) begin
      exValid    <= 1'b0;
      exRegWrite <= 1'b0;
      exMemRead  <= 1'b0;
      exMemWrite <= 1'b0;
      exMemToReg <= 1'b0;
      exBranch   <= 1'b0;
      illegal    <= 1'b0;
      aluCtr     <= 4'b0010;
      exDest     <= '0;
      alu_src_q  <= 1'b0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
    end else begin
      // Data fields load unconditionally; only control is squashed in a bubble.
      exDest    <= idRegDst ? idRd : idRt;
      alu_src_q <= idAluSrc;
      rs_q      <= idRs;
      rt_q      <= idRt;
      rd1_q     <= idReadData1;
      rd2_q     <= idReadData2;
      imm_q     <= idImm;
      if (bubble) begin
        exValid    <= 1'b0;
        exRegWrite <= 1'b0;
        exMemRead  <= 1'b0;
        exMemWrite <= 1'b0;
        exMemToReg <= 1'b0;
        exBranch   <= 1'b0;
        illegal    <= 1'b0;
        aluCtr     <= 4'b0010;
      end else begin
        exValid    <= 1'b1;
        exRegWrite <= idRegWrite && !illegal_d;
        exMemRead  <= idMemRead;
        exMemWrite <= idMemWrite;
        exMemToReg <= idMemToReg;
        exBranch   <= idBranch;
        illegal    <= illegal_d;
        aluCtr     <= ctr_d;
      end
    end
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB.
  always_comb begin
    fwd_a = rd1_q;
    if (exmemRegWrite && (exmemRd != '0) && (exmemRd == rs_q))
      fwd_a = exmemAluRes;
    else if (memwbRegWrite && (memwbRd != '0) && (memwbRd == rs_q))
      fwd_a = memwbData;
  end

  always_comb begin
    fwd_b = rd2_q;
    if (exmemRegWrite && (exmemRd != '0) && (exmemRd == rt_q))
      fwd_b = exmemAluRes;
    else if (memwbRegWrite && (memwbRd != '0) && (memwbRd == rt_q))
      fwd_b = memwbData;
  end

  assign aluInput1 = fwd_a;
  assign storeData = fwd_b;
  assign aluInput2 = alu_src_q ? imm_q : fwd_b;

endmodule
